// File: rtl/cla_slice_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cla_slice_sequencer
// Description : Multi-cycle WIDTH-bit adder. A single 4-bit propagate/generate
//               lookahead slice is stepped across the operands one nibble per
//               clock, LSB nibble first, carrying the group carry between steps
//               and assembling the result in a registered sum.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_slice_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Number of nibble steps and width of the nibble index (at least one bit).
    localparam int c_NG    = WIDTH / 4;
    localparam int c_IDX_W = (c_NG > 1) ? $clog2(c_NG) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NG - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic               carry_q,  carry_d;
    logic [c_IDX_W-1:0] idx_q,    idx_d;
    logic [WIDTH-1:0]   sum_q,    sum_d;
    logic               cout_q,   cout_d;
    logic               ovf_q,    ovf_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic [c_IDX_W+1:0] w_sh;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [3:0]         w_p;
    logic [3:0]         w_g;
    logic [4:0]         w_c;
    logic [3:0]         w_s;
    logic [WIDTH-1:0]   w_nib_mask;
    logic [WIDTH-1:0]   w_nib_sum;
    logic               w_last;

    // Slice datapath: select the current nibble and form P/G, lookahead carries and sum bits.
    always_comb begin
        w_sh    = {idx_q, 2'b00};
        w_a_nib = 4'(a_q >> w_sh);
        w_b_nib = 4'(b_q >> w_sh);
        w_p     = w_a_nib ^ w_b_nib;
        w_g     = w_a_nib & w_b_nib;
        w_c     = '0;
        w_c[0]  = carry_q;
        for (int i = 0; i < 4; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
        w_s        = w_p ^ w_c[3:0];
        w_nib_mask = WIDTH'(4'hF) << w_sh;
        w_nib_sum  = WIDTH'(w_s) << w_sh;
        w_last     = (idx_q == c_LAST_IDX);
    end

    // Next-state logic: accept in IDLE, one nibble per RUN cycle, one-cycle DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                sum_d   = (sum_q & ~w_nib_mask) | w_nib_sum;
                carry_d = w_c[4];
                if (w_last) begin
                    // Index holds at the last nibble; MSB carries give cout and overflow.
                    cout_d  = w_c[4];
                    ovf_d   = w_c[3] ^ w_c[4];
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_slice_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_slice_sequencer
// Description : Self-checking bench for cla_slice_sequencer (WIDTH=16). The
//               expected results come from plain integer addition of the
//               accepted operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_slice_sequencer;

    localparam int WIDTH = 16;
    localparam int NG    = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_checks = 0;
    int n_fail   = 0;

    cla_slice_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Reference: full-width integer add; bit WIDTH is the carry out.
    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                               input logic cv);
        return {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
    endfunction

    // Signed overflow: same-sign operands giving a result of the other sign.
    function automatic logic ref_ovf(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                     input logic cv);
        logic [WIDTH:0] r;
        r = ref_add(av, bv, cv);
        return (av[WIDTH-1] == bv[WIDTH-1]) && (r[WIDTH-1] != av[WIDTH-1]);
    endfunction

    // Low 4*k bits of the final sum; nibbles not yet written still read as zero.
    function automatic logic [WIDTH-1:0] partial_mask(input int k);
        logic [WIDTH-1:0] ones;
        ones = '1;
        return ones >> (WIDTH - 4 * k);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge (edge 0), then scramble the inputs.
    task automatic accept(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'($urandom);
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
        step();
        step();
        n_checks++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_quiet[%0d]: got busy=%b done=%b, want 0 0", i, busy, done);
            end
        end
    endtask

    task automatic test_directed;
        logic [WIDTH-1:0] va [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h8000, 16'hA5C3};
        logic [WIDTH-1:0] vb [6] = '{16'h4321, 16'h0001, 16'h0001, 16'h0000, 16'h8000, 16'h5A3C};
        logic             vc [6] = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b0,     1'b1};
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] exp_part;
        logic             exp_ovf;
        for (int t = 0; t < 6; t++) begin
            r       = ref_add(va[t], vb[t], vc[t]);
            exp_ovf = ref_ovf(va[t], vb[t], vc[t]);
            accept(va[t], vb[t], vc[t]);
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0 || sum !== '0) begin
                n_fail++;
                $display("FAIL dir%0d_accept: got busy=%b done=%b sum=%h, want 1 0 0000",
                         t, busy, done, sum);
            end
            for (int k = 1; k <= NG; k++) begin
                // Operands on the pins are don't-care once accepted.
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
                step();
                exp_part = r[WIDTH-1:0] & partial_mask(k);
                n_checks++;
                if (sum !== exp_part || busy !== (k < NG) || done !== (k == NG)) begin
                    n_fail++;
                    $display("FAIL dir%0d_edge%0d: got sum=%h busy=%b done=%b, want sum=%h busy=%b done=%b",
                             t, k, sum, busy, done, exp_part, (k < NG), (k == NG));
                end
            end
            n_checks++;
            if (cout !== r[WIDTH] || ovf !== exp_ovf) begin
                n_fail++;
                $display("FAIL dir%0d_flags: got cout=%b ovf=%b, want cout=%b ovf=%b",
                         t, cout, ovf, r[WIDTH], exp_ovf);
            end
            step();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || sum !== r[WIDTH-1:0] || cout !== r[WIDTH]) begin
                n_fail++;
                $display("FAIL dir%0d_hold: got done=%b busy=%b sum=%h cout=%b, want 0 0 %h %b",
                         t, done, busy, sum, cout, r[WIDTH-1:0], r[WIDTH]);
            end
        end
    endtask

    task automatic test_start_during_run;
        accept(16'h0001, 16'h0001, 1'b0);
        step();
        a     = 16'hAAAA;
        b     = 16'h5555;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        n_checks++;
        if (done !== 1'b1 || sum !== 16'h0002 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_run_result: got done=%b sum=%h cout=%b ovf=%b, want 1 0002 0 0",
                     done, sum, cout, ovf);
        end
        step();
        step();
        n_checks++;
        if (busy !== 1'b0 || sum !== 16'h0002) begin
            n_fail++;
            $display("FAIL start_in_run_not_queued: got busy=%b sum=%h, want 0 0002", busy, sum);
        end
    endtask

    task automatic test_reset_mid;
        accept(16'h1234, 16'h1111, 1'b0);
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_no_done[%0d]: got done=%b busy=%b, want 0 0", i, done, busy);
            end
        end
        rst_n = 1'b1;
        accept(16'h00FF, 16'h0001, 1'b0);
        for (int k = 0; k < NG; k++) step();
        n_checks++;
        if (done !== 1'b1 || sum !== 16'h0100 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_recover: got done=%b sum=%h cout=%b ovf=%b, want 1 0100 0 0",
                     done, sum, cout, ovf);
        end
        step();
    endtask

    task automatic test_back_to_back;
        logic [WIDTH:0] r1;
        logic [WIDTH:0] r2;
        r1    = ref_add(16'h1111, 16'h2222, 1'b0);
        r2    = ref_add(16'h0F0F, 16'h00F1, 1'b1);
        a     = 16'h1111;
        b     = 16'h2222;
        cin   = 1'b0;
        start = 1'b1;
        step();
        a   = 16'h0F0F;
        b   = 16'h00F1;
        cin = 1'b1;
        for (int k = 0; k < NG; k++) step();
        n_checks++;
        if (done !== 1'b1 || sum !== r1[WIDTH-1:0]) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%b sum=%h, want 1 %h", done, sum, r1[WIDTH-1:0]);
        end
        step();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: got busy=%b done=%b, want 0 0", busy, done);
        end
        step();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || sum !== '0) begin
            n_fail++;
            $display("FAIL b2b_reaccept: got busy=%b sum=%h, want 1 0000", busy, sum);
        end
        for (int k = 0; k < NG; k++) step();
        n_checks++;
        if (done !== 1'b1 || sum !== r2[WIDTH-1:0] || cout !== r2[WIDTH]) begin
            n_fail++;
            $display("FAIL b2b_second: got done=%b sum=%h cout=%b, want 1 %h %b",
                     done, sum, cout, r2[WIDTH-1:0], r2[WIDTH]);
        end
        step();
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        logic [WIDTH:0]   r;
        logic             exp_ovf;
        int               cyc;
        for (int t = 0; t < 40; t++) begin
            ra      = WIDTH'($urandom);
            rb      = WIDTH'($urandom);
            rc      = 1'($urandom);
            r       = ref_add(ra, rb, rc);
            exp_ovf = ref_ovf(ra, rb, rc);
            accept(ra, rb, rc);
            cyc = 0;
            while (done !== 1'b1 && cyc < 3 * NG) begin
                start = 1'($urandom);
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
                step();
                cyc++;
            end
            start = 1'b0;
            n_checks++;
            if (done !== 1'b1 || cyc != NG) begin
                n_fail++;
                $display("FAIL rnd%0d_latency: got done=%b after %0d cycles, want done=1 after %0d",
                         t, done, cyc, NG);
            end
            n_checks++;
            if (sum !== r[WIDTH-1:0] || cout !== r[WIDTH] || ovf !== exp_ovf) begin
                n_fail++;
                $display("FAIL rnd%0d_result: %h+%h+%b got sum=%h cout=%b ovf=%b, want %h %b %b",
                         t, ra, rb, rc, sum, cout, ovf, r[WIDTH-1:0], r[WIDTH], exp_ovf);
            end
            step();
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        test_reset();
        test_directed();
        test_start_during_run();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
